// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared types and constants for the multi-cycle bus sequencer.
//            Holds the sequencer state enum, the full-word byte-lane
//            pattern and the mask of address bits that are forced to zero
//            on every bus access.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  // Sequencer states. One instruction walks FETCH -> EXEC [-> MEM -> WB].
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } seq_state_t;

  // All four byte lanes: used for every instruction fetch.
  localparam logic [3:0] BE_WORD = 4'hF;

  // Low address bits cleared on the bus; the bus is word addressed and
  // sub-word selection is carried entirely by byteenable.
  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//            Cleared only by the asynchronous active-low reset.
// Ports    : clk      - system clock, rising edge
//            reset_n  - asynchronous active-low reset (clears count)
//            inc      - count this cycle
//            count    - current count value
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : mips_cpu_sat_counter
`default_nettype wire

// File: rtl/mips_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_sequencer
// Purpose  : Multi-cycle sequencer sharing one Avalon-style memory port
//            between instruction fetch and data load/store. Latches the
//            fetched instruction and load data, issues the data access the
//            decoder requests and produces the commit strobe that gates PC
//            update and register-file write.
// Ports    : clk, reset_n           - clock / async active-low reset
//            pc, halt_req           - datapath PC and halt condition
//            data_read, data_write  - decoder load/store request (in EXEC)
//            data_addr, data_wdata,
//            data_be                - load/store address, data, lanes
//            waitrequest, readdata  - bus stall / read data
//            address, read, write,
//            byteenable, writedata  - bus master outputs
//            instr, load_data       - latched instruction / load result
//            commit, active         - retire pulse / CPU running
//            req_err                - sticky simultaneous read+write request
//            stall_count            - saturating bus-stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt_req,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [3:0]        data_be,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic [31:0]       instr,
  output logic [DATA_W-1:0] load_data,
  output logic              commit,
  output logic              active,
  output logic              req_err,
  output logic [CNT_W-1:0]  stall_count
);

  seq_state_t state;
  seq_state_t state_next;

  // Direction of the pending data access, captured while in EXEC so MEM
  // no longer depends on the decoder's request lines.
  logic mem_is_write;

  logic capture_instr;
  logic capture_load;
  logic flag_req_err;

  // Word-aligned views of the two address sources.
  logic [ADDR_W-1:0] pc_aligned;
  logic [ADDR_W-1:0] data_aligned;

  assign pc_aligned   = {pc[ADDR_W-1:2], pc[1:0] & ~ADDR_ALIGN_MASK};
  assign data_aligned = {data_addr[ADDR_W-1:2], data_addr[1:0] & ~ADDR_ALIGN_MASK};

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_is_write <= 1'b0;
      instr        <= '0;
      load_data    <= '0;
      req_err      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == EXEC) begin
        mem_is_write <= data_write;
      end
      if (capture_instr) begin
        instr <= readdata[31:0];
      end
      if (capture_load) begin
        load_data <= readdata;
      end
      if (flag_req_err) begin
        req_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and bus outputs. Outputs are a function of the state; the
  // address/lane/data fields are passed through from the datapath, which
  // keeps them stable because instr does not change during a stall.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    byteenable    = '0;
    writedata     = '0;
    commit        = 1'b0;
    active        = 1'b0;
    capture_instr = 1'b0;
    capture_load  = 1'b0;
    flag_req_err  = 1'b0;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        active     = 1'b1;
        read       = 1'b1;
        address    = pc_aligned;
        byteenable = BE_WORD;
        if (!waitrequest) begin
          capture_instr = 1'b1;
          state_next    = EXEC;
        end
      end

      EXEC: begin
        active = 1'b1;
        if (data_write) begin
          // A store wins over a simultaneous load; the conflict is recorded.
          flag_req_err = data_read;
          state_next   = MEM;
        end else if (data_read) begin
          state_next = MEM;
        end else begin
          commit     = 1'b1;
          state_next = halt_req ? HALT : FETCH;
        end
      end

      MEM: begin
        active     = 1'b1;
        address    = data_aligned;
        byteenable = data_be;
        if (mem_is_write) begin
          write     = 1'b1;
          writedata = data_wdata;
        end else begin
          read = 1'b1;
        end
        if (!waitrequest) begin
          capture_load = !mem_is_write;
          state_next   = WB;
        end
      end

      WB: begin
        active     = 1'b1;
        commit     = 1'b1;
        state_next = halt_req ? HALT : FETCH;
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall statistics: any strobed cycle the slave holds off.
  // --------------------------------------------------------------------------
  mips_cpu_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((read | write) & waitrequest),
    .count   (stall_count)
  );

endmodule : mips_cpu_bus_sequencer
`default_nettype wire

// File: tb/tb_mips_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus_sequencer
// Purpose  : Self-checking bench for mips_cpu_bus_sequencer. Acts as the
//            memory slave and the decoder; expected bus activity, latched
//            values, stall count and error flag come from an
//            instruction-level model of the sequencer's rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;
  localparam int SAT    = (1 << CNT_W) - 1;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              halt_req = 1'b0;
  logic              data_read = 1'b0;
  logic              data_write = 1'b0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] data_wdata = '0;
  logic [3:0]        data_be = '0;
  logic              waitrequest = 1'b0;
  logic [DATA_W-1:0] readdata = '0;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [DATA_W-1:0] writedata;
  logic [31:0]       instr;
  logic [DATA_W-1:0] load_data;
  logic              commit;
  logic              active;
  logic              req_err;
  logic [CNT_W-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  // Instruction-level model state
  int          exp_stalls = 0;
  logic        exp_req_err = 1'b0;
  logic [31:0] exp_load = '0;

  always #5 clk = ~clk;

  mips_cpu_bus_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .halt_req    (halt_req),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_be     (data_be),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .instr       (instr),
    .load_data   (load_data),
    .commit      (commit),
    .active      (active),
    .req_err     (req_err),
    .stall_count (stall_count)
  );

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Runs one instruction starting in a FETCH cycle and checks every cycle
  // against the expected bus behaviour for that instruction kind.
  task automatic run_instr(input int kind, input logic [31:0] pc_v,
                           input logic [31:0] daddr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] iword,
                           input logic [31:0] rword, input int fs,
                           input int ms, input bit halt);
    bit          is_mem;
    bit          is_wr;
    logic [31:0] pc_al;
    logic [31:0] da_al;
    logic [31:0] exp_wd;
    is_mem = (kind != K_ALU);
    is_wr  = (kind == K_STORE) || (kind == K_BOTH);
    pc_al  = {pc_v[31:2], 2'b00};
    da_al  = {daddr[31:2], 2'b00};
    exp_wd = is_wr ? wdata : 32'h0;

    for (int i = 0; i <= fs; i++) begin
      @(negedge clk);
      pc          = pc_v;
      waitrequest = (i < fs);
      readdata    = (i < fs) ? $urandom : iword;
      data_read   = 1'($urandom);
      data_write  = 1'($urandom);
      halt_req    = 1'($urandom);
      #1;
      checks++;
      if (read !== 1'b1 || write !== 1'b0 || address !== pc_al ||
          byteenable !== 4'hF || active !== 1'b1 || commit !== 1'b0) begin
        errors++;
        $display("FAIL fetch_bus: read=%0b write=%0b addr=%h be=%h active=%0b commit=%0b, want read=1 write=0 addr=%h be=f active=1 commit=0",
                 read, write, address, byteenable, active, commit, pc_al);
      end
      if (i < fs) exp_stalls = sat_inc(exp_stalls);
    end

    @(negedge clk);
    waitrequest = 1'($urandom);
    readdata    = $urandom;
    pc          = $urandom;
    data_read   = (kind == K_LOAD) || (kind == K_BOTH);
    data_write  = is_wr;
    data_addr   = daddr;
    data_be     = be;
    data_wdata  = wdata;
    halt_req    = is_mem ? 1'($urandom) : halt;
    #1;
    checks++;
    if (instr !== iword) begin
      errors++;
      $display("FAIL exec_instr: instr=%h want %h", instr, iword);
    end
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || commit !== !is_mem || active !== 1'b1) begin
      errors++;
      $display("FAIL exec_ctrl: read=%0b write=%0b commit=%0b active=%0b, want 0 0 %0b 1",
               read, write, commit, active, !is_mem);
    end

    if (is_mem) begin
      if (kind == K_BOTH) exp_req_err = 1'b1;
      for (int j = 0; j <= ms; j++) begin
        @(negedge clk);
        waitrequest = (j < ms);
        readdata    = (j < ms) ? $urandom : rword;
        halt_req    = 1'($urandom);
        pc          = $urandom;
        #1;
        checks++;
        if (read !== !is_wr || write !== is_wr || address !== da_al ||
            byteenable !== be || writedata !== exp_wd || commit !== 1'b0 ||
            active !== 1'b1) begin
          errors++;
          $display("FAIL mem_bus: read=%0b write=%0b addr=%h be=%h wd=%h commit=%0b active=%0b, want %0b %0b %h %h %h 0 1",
                   read, write, address, byteenable, writedata, commit, active,
                   !is_wr, is_wr, da_al, be, exp_wd);
        end
        checks++;
        if (req_err !== exp_req_err) begin
          errors++;
          $display("FAIL mem_req_err: req_err=%0b want %0b", req_err, exp_req_err);
        end
        if (j < ms) exp_stalls = sat_inc(exp_stalls);
      end
      if (!is_wr) exp_load = rword;

      @(negedge clk);
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      halt_req    = halt;
      #1;
      checks++;
      if (commit !== 1'b1 || read !== 1'b0 || write !== 1'b0 || active !== 1'b1) begin
        errors++;
        $display("FAIL wb_ctrl: commit=%0b read=%0b write=%0b active=%0b, want 1 0 0 1",
                 commit, read, write, active);
      end
      checks++;
      if (load_data !== exp_load) begin
        errors++;
        $display("FAIL wb_load_data: load_data=%h want %h", load_data, exp_load);
      end
    end

    checks++;
    if (int'(stall_count) != exp_stalls) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", stall_count, exp_stalls);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || commit !== 1'b0 || active !== 1'b0 ||
        address !== '0 || byteenable !== '0 || writedata !== '0 || instr !== '0 ||
        load_data !== '0 || req_err !== 1'b0 || stall_count !== '0) begin
      errors++;
      $display("FAIL reset_state: rd=%0b wr=%0b cm=%0b act=%0b addr=%h be=%h wd=%h instr=%h ld=%h err=%0b sc=%0d, want all zero",
               read, write, commit, active, address, byteenable, writedata,
               instr, load_data, req_err, stall_count);
    end
    repeat (2) @(negedge clk);
    reset_n     = 1'b1;
    exp_stalls  = 0;
    exp_req_err = 1'b0;
    exp_load    = '0;
    #1;
    checks++;
    if (active !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: active=%0b read=%0b want 0 0", active, read);
    end
  endtask

  task automatic test_alu;
    run_instr(K_ALU, 32'hBFC0_0000, 32'h0, 4'h0, 32'h0, 32'h2408_0005,
              32'h0, 0, 0, 1'b0);
    run_instr(K_ALU, 32'hBFC0_0007, 32'h0, 4'h0, 32'h0, 32'h0000_0020,
              32'h0, 2, 0, 1'b0);
  endtask

  task automatic test_load_stall;
    run_instr(K_LOAD, 32'hBFC0_0008, 32'h0000_1006, 4'b1100, 32'hAAAA_5555,
              32'h8D09_0000, 32'hDEAD_BEEF, 0, 3, 1'b0);
  endtask

  task automatic test_store;
    run_instr(K_STORE, 32'hBFC0_000C, 32'h0000_2000, 4'hF, 32'h1234_5678,
              32'hAD09_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
  endtask

  task automatic test_read_write_conflict;
    run_instr(K_BOTH, 32'hBFC0_0010, 32'h0000_3003, 4'b0011, 32'hCAFE_F00D,
              32'hAD0A_0004, 32'h5555_AAAA, 1, 1, 1'b0);
    // req_err must persist across the following fetch
    run_instr(K_ALU, 32'hBFC0_0014, 32'h0, 4'h0, 32'h0, 32'h0100_0020,
              32'h0, 1, 0, 1'b0);
    checks++;
    if (req_err !== 1'b1) begin
      errors++;
      $display("FAIL req_err_sticky: req_err=%0b want 1", req_err);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 3), $urandom, $urandom, 4'($urandom),
                $urandom, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_stall_saturation;
    run_instr(K_LOAD, 32'h0000_0040, 32'h0000_0100, 4'hF, 32'h0,
              32'h8C01_0000, 32'h0BAD_F00D, 4, SAT + 6, 1'b0);
    run_instr(K_STORE, 32'h0000_0044, 32'h0000_0104, 4'h1, 32'h77,
              32'hAC01_0000, 32'h0, 3, 2, 1'b0);
  endtask

  task automatic test_midfetch_reset;
    @(negedge clk);
    pc          = 32'h0000_0080;
    waitrequest = 1'b1;
    #1;
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL midfetch_pre: read=%0b want 1", read);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || active !== 1'b0 || instr !== '0 || load_data !== '0 ||
        stall_count !== '0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_reset: read=%0b active=%0b instr=%h ld=%h sc=%0d err=%0b, want all zero",
               read, active, instr, load_data, stall_count, req_err);
    end
    @(negedge clk);
    waitrequest = 1'b0;
    reset_n     = 1'b1;
    exp_stalls  = 0;
    exp_req_err = 1'b0;
    exp_load    = '0;
    #1;
    checks++;
    if (active !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_idle: active=%0b read=%0b want 0 0", active, read);
    end
    run_instr(K_LOAD, 32'h0000_0080, 32'h0000_0204, 4'hF, 32'h0,
              32'h8C02_0004, 32'h1357_9BDF, 1, 0, 1'b0);
  endtask

  task automatic test_halt;
    run_instr(K_LOAD, 32'h0000_0084, 32'h0000_0300, 4'h3, 32'h0,
              32'h8C03_0000, 32'h2468_ACE0, 0, 1, 1'b0);
    run_instr(K_ALU, 32'h0000_0088, 32'h0, 4'h0, 32'h0, 32'h0800_0000,
              32'h0, 0, 0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      waitrequest = 1'($urandom);
      pc          = $urandom;
      data_read   = 1'($urandom);
      data_write  = 1'($urandom);
      halt_req    = 1'($urandom);
      #1;
      checks++;
      if (active !== 1'b0 || read !== 1'b0 || write !== 1'b0 || commit !== 1'b0) begin
        errors++;
        $display("FAIL halt_quiet: cycle %0d active=%0b read=%0b write=%0b commit=%0b, want 0 0 0 0",
                 c, active, read, write, commit);
      end
    end
    checks++;
    if (int'(stall_count) != exp_stalls) begin
      errors++;
      $display("FAIL halt_stall_count: got %0d want %0d", stall_count, exp_stalls);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store();
    test_read_write_conflict();
    test_random();
    test_stall_saturation();
    test_midfetch_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mips_cpu_bus_sequencer
`default_nettype wire
